dmem_bus_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: master 0 is the mem-stage LSU port, master 1 is the instruction-fetch port.
- Uses req/gnt/rvalid handshake; responses return in order.
- Fixed priority to master 0, with a starvation counter that forces a master-1 grant.
- Tracks outstanding transactions in an ID FIFO so each rvalid is routed to its issuer.

---
 rtl/dmem_bus_arbiter_if.sv | 54 +++++
 rtl/dmem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory port.
// Latency: none; this is wiring only.
// Backpressure: req is held until gnt; rvalid cannot be stalled.
interface dmem_bus_arbiter_if;
  // master 0: mem-stage LSU
  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_be;
  logic        m0_gnt;
  logic        m0_rvalid;
  // master 1: instruction fetch
  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;
  logic        m1_gnt;
  logic        m1_rvalid;
  // shared response data
  logic [31:0] rdata;
  // memory side
  logic        s_req;
  logic        s_wr;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_gnt;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  // sticky error flag
  logic        resp_err;

  // Arbiter side: takes requests from both masters and drives the memory port.
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata, m0_be,
    input  m1_req, m1_wr, m1_addr, m1_wdata, m1_be,
    input  s_gnt, s_rdata, s_rvalid,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output s_req, s_wr, s_addr, s_wdata, s_be,
    output resp_err
  );

  // Environment side: the requesters plus the memory model.
  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata, m0_be,
    output m1_req, m1_wr, m1_addr, m1_wdata, m1_be,
    output s_gnt, s_rdata, s_rvalid,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  s_req, s_wr, s_addr, s_wdata, s_be,
    input  resp_err
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-master data-memory arbiter: fixed priority to the LSU, starvation escape for fetch, in-order response routing.
// Latency: grant is combinational from s_gnt (0 cycles); rvalid is routed in the same cycle as s_rvalid.
// Backpressure: s_req drops while OUTSTANDING transactions are unanswered (no same-cycle pop bypass).
module dmem_bus_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_bus_arbiter_if.slave bus
);

  // OUTSTANDING is a power of two, so the pointers wrap for free at PW bits.
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // ID FIFO: one bit per outstanding transaction, 0 = LSU, 1 = fetch.
  logic [OUTSTANDING-1:0] r_id;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [SW-1:0]          r_starve_cnt;
  logic                   r_resp_err;

  logic w_full;
  logic w_empty;
  logic w_sel;
  logic w_s_req;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_m0_gnt;
  logic w_m1_gnt;
  logic w_starved;

  // Occupancy is taken from the registered count only; a response arriving
  // while full does not free a slot until the next cycle.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Fetch wins when it is alone or once the LSU has been granted STARVE_LIMIT
  // times in a row while fetch was waiting.
  assign w_starved = (r_starve_cnt == STARVE_MAX);
  assign w_sel     = bus.m1_req & (~bus.m0_req | w_starved);

  assign w_s_req  = (bus.m0_req | bus.m1_req) & ~w_full;
  assign w_push   = w_s_req & bus.s_gnt;
  assign w_m0_gnt = w_push & ~w_sel;
  assign w_m1_gnt = w_push &  w_sel;

  // A response with nothing outstanding is dropped (flagged via resp_err).
  assign w_pop  = bus.s_rvalid & ~w_empty;
  assign w_head = r_id[r_rd_ptr];

  // Request mux: sel may change while a req is held; nothing commits until gnt.
  assign bus.s_req   = w_s_req;
  assign bus.s_wr    = w_sel ? bus.m1_wr    : bus.m0_wr;
  assign bus.s_addr  = w_sel ? bus.m1_addr  : bus.m0_addr;
  assign bus.s_wdata = w_sel ? bus.m1_wdata : bus.m0_wdata;
  assign bus.s_be    = w_sel ? bus.m1_be    : bus.m0_be;

  assign bus.m0_gnt    = w_m0_gnt;
  assign bus.m1_gnt    = w_m1_gnt;
  assign bus.m0_rvalid = w_pop & ~w_head;
  assign bus.m1_rvalid = w_pop &  w_head;
  assign bus.rdata     = bus.s_rdata;
  assign bus.resp_err  = r_resp_err;

  // Record the issuer of each accepted transaction at the write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id     <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_id[r_wr_ptr] <= w_sel;
      r_wr_ptr       <= r_wr_ptr + PW'(1);
    end
  end

  // Advance the read pointer on each routed response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Count LSU grants taken while fetch waits, saturating at STARVE_LIMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_m1_gnt) begin
      r_starve_cnt <= '0;
    end else if (bus.m1_req & w_m0_gnt & ~w_starved) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  // Sticky flag for responses that match no outstanding transaction,
  // including late responses to transactions dropped by a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_err <= 1'b0;
    end else if (bus.s_rvalid & w_empty) begin
      r_resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter (OUTSTANDING=2, STARVE_LIMIT=4).
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
// Each scenario task checks its own expected values inline.
module tb_dmem_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  dmem_bus_arbiter_if bus ();

  dmem_bus_arbiter #(
    .OUTSTANDING  (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
    bus.s_gnt = 1'b0; bus.s_rdata = '0; bus.s_rvalid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset_n = 1'b0;
    bus.m0_req = 1'b1;
    @(negedge clk);
    n_total++; if (bus.s_req !== 1'b1) $display("FAIL reset_s_req got %b want 1", bus.s_req); else n_pass++;
    n_total++; if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0) $display("FAIL reset_gnt got %b%b want 00", bus.m0_gnt, bus.m1_gnt); else n_pass++;
    n_total++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b%b want 00", bus.m0_rvalid, bus.m1_rvalid); else n_pass++;
    n_total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_resp_err got %b want 0", bus.resp_err); else n_pass++;
    next_cycle();
    idle_inputs();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_read();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h100; bus.m0_be = 4'hF; bus.s_gnt = 1'b1;
    bus.m1_addr = 32'h999;
    @(negedge clk);
    n_total++; if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) $display("FAIL single_gnt got %b%b want 10", bus.m0_gnt, bus.m1_gnt); else n_pass++;
    n_total++; if (bus.s_addr !== 32'h100 || bus.s_wr !== 1'b0) $display("FAIL single_addr got %h/%b want 00000100/0", bus.s_addr, bus.s_wr); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_total++; if (bus.s_req !== 1'b0 || bus.m0_rvalid !== 1'b0) $display("FAIL single_idle got req=%b rv=%b want 0/0", bus.s_req, bus.m0_rvalid); else n_pass++;
    next_cycle();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0) $display("FAIL single_rvalid got %b%b want 10", bus.m0_rvalid, bus.m1_rvalid); else n_pass++;
    n_total++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL single_rdata got %h want deadbeef", bus.rdata); else n_pass++;
    next_cycle();
    idle_inputs();
  endtask

  // Starts right after test_single_read: two grants in a row prove the count returned to 0.
  task automatic test_fifo_full();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h104; bus.s_gnt = 1'b1;
    @(negedge clk);
    n_total++; if (bus.m0_gnt !== 1'b1) $display("FAIL full_gnt0 got %b want 1", bus.m0_gnt); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.m0_gnt !== 1'b1) $display("FAIL full_gnt1 got %b want 1", bus.m0_gnt); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.s_req !== 1'b0 || bus.m0_gnt !== 1'b0) $display("FAIL full_block got req=%b gnt=%b want 0/0", bus.s_req, bus.m0_gnt); else n_pass++;
    next_cycle();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'hA1;
    @(negedge clk);
    n_total++; if (bus.s_req !== 1'b0 || bus.m0_rvalid !== 1'b1) $display("FAIL full_nobypass got req=%b rv=%b want 0/1", bus.s_req, bus.m0_rvalid); else n_pass++;
    next_cycle();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    n_total++; if (bus.s_req !== 1'b1 || bus.m0_gnt !== 1'b1) $display("FAIL full_reopen got req=%b gnt=%b want 1/1", bus.s_req, bus.m0_gnt); else n_pass++;
    next_cycle();
    bus.m0_req = 1'b0; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b1) $display("FAIL full_drain0 got %b want 1", bus.m0_rvalid); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b1) $display("FAIL full_drain1 got %b want 1", bus.m0_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_total++; if (bus.resp_err !== 1'b0) $display("FAIL full_resp_err got %b want 0", bus.resp_err); else n_pass++;
    next_cycle();
  endtask

  task automatic test_mux();
    bus.m0_req = 1'b1; bus.m0_wr = 1'b1; bus.m0_addr = 32'h300; bus.m0_wdata = 32'hCAFEF00D; bus.m0_be = 4'h3;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = 32'h40;  bus.m1_wdata = 32'h5555AAAA; bus.m1_be = 4'hF;
    @(negedge clk);
    n_total++; if (bus.s_req !== 1'b1 || bus.s_wr !== 1'b1 || bus.s_addr !== 32'h300) $display("FAIL mux_m0_ctl got req=%b wr=%b addr=%h want 1/1/00000300", bus.s_req, bus.s_wr, bus.s_addr); else n_pass++;
    n_total++; if (bus.s_wdata !== 32'hCAFEF00D || bus.s_be !== 4'h3) $display("FAIL mux_m0_data got %h/%h want cafef00d/3", bus.s_wdata, bus.s_be); else n_pass++;
    n_total++; if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0) $display("FAIL mux_nognt got %b%b want 00", bus.m0_gnt, bus.m1_gnt); else n_pass++;
    next_cycle();
    bus.m0_req = 1'b0;
    @(negedge clk);
    n_total++; if (bus.s_addr !== 32'h40 || bus.s_wr !== 1'b0 || bus.s_be !== 4'hF || bus.s_wdata !== 32'h5555AAAA) $display("FAIL mux_m1 got addr=%h wr=%b be=%h wd=%h want 00000040/0/f/5555aaaa", bus.s_addr, bus.s_wr, bus.s_be, bus.s_wdata); else n_pass++;
    next_cycle();
    bus.s_gnt = 1'b1;
    @(negedge clk);
    n_total++; if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) $display("FAIL mux_m1_gnt got %b%b want 01 (m0,m1)", bus.m0_gnt, bus.m1_gnt); else n_pass++;
    next_cycle();
    idle_inputs();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'h77;
    @(negedge clk);
    n_total++; if (bus.m1_rvalid !== 1'b1 || bus.m0_rvalid !== 1'b0) $display("FAIL mux_m1_rvalid got %b%b want 01 (m0,m1)", bus.m0_rvalid, bus.m1_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [6:0] exp_m1;
    exp_m1 = 7'b0010000;  // bit c: master-1 grant expected in cycle c
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 32'hA0;
    bus.m1_req = 1'b1; bus.m1_addr = 32'hB0;
    bus.s_gnt = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.s_rvalid = (c > 0);
      @(negedge clk);
      n_total++;
      if (bus.m0_gnt !== ~exp_m1[c] || bus.m1_gnt !== exp_m1[c])
        $display("FAIL contend_gnt c=%0d got m0=%b m1=%b want m0=%b m1=%b", c, bus.m0_gnt, bus.m1_gnt, ~exp_m1[c], exp_m1[c]);
      else n_pass++;
      n_total++;
      if (bus.s_addr !== (exp_m1[c] ? 32'hB0 : 32'hA0))
        $display("FAIL contend_addr c=%0d got %h want %h", c, bus.s_addr, exp_m1[c] ? 32'hB0 : 32'hA0);
      else n_pass++;
      if (c > 0) begin
        n_total++;
        if (bus.m1_rvalid !== exp_m1[c-1] || bus.m0_rvalid !== ~exp_m1[c-1])
          $display("FAIL contend_route c=%0d got m0=%b m1=%b want m0=%b m1=%b", c, bus.m0_rvalid, bus.m1_rvalid, ~exp_m1[c-1], exp_m1[c-1]);
        else n_pass++;
      end
      next_cycle();
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0) $display("FAIL contend_last got %b%b want 10", bus.m0_rvalid, bus.m1_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_interleave();
    bus.m1_req = 1'b1; bus.m1_addr = 32'h0; bus.s_gnt = 1'b1;
    @(negedge clk);
    n_total++; if (bus.m1_gnt !== 1'b1 || bus.s_addr !== 32'h0) $display("FAIL inter_g1 got gnt=%b addr=%h want 1/00000000", bus.m1_gnt, bus.s_addr); else n_pass++;
    next_cycle();
    bus.m1_req = 1'b0; bus.m0_req = 1'b1; bus.m0_addr = 32'h200;
    @(negedge clk);
    n_total++; if (bus.m0_gnt !== 1'b1 || bus.s_addr !== 32'h200) $display("FAIL inter_g0 got gnt=%b addr=%h want 1/00000200", bus.m0_gnt, bus.s_addr); else n_pass++;
    next_cycle();
    idle_inputs();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'h11;
    @(negedge clk);
    n_total++; if (bus.m1_rvalid !== 1'b1 || bus.m0_rvalid !== 1'b0 || bus.rdata !== 32'h11) $display("FAIL inter_r1 got m0=%b m1=%b d=%h want 0/1/00000011", bus.m0_rvalid, bus.m1_rvalid, bus.rdata); else n_pass++;
    next_cycle();
    bus.s_rdata = 32'h22;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0 || bus.rdata !== 32'h22) $display("FAIL inter_r0 got m0=%b m1=%b d=%h want 1/0/00000022", bus.m0_rvalid, bus.m1_rvalid, bus.rdata); else n_pass++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_spurious();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'h33;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) $display("FAIL spur_rvalid got %b%b want 00", bus.m0_rvalid, bus.m1_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_total++; if (bus.resp_err !== 1'b1) $display("FAIL spur_set got %b want 1", bus.resp_err); else n_pass++;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.resp_err !== 1'b1) $display("FAIL spur_hold got %b want 1", bus.resp_err); else n_pass++;
    next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    n_total++; if (bus.resp_err !== 1'b0) $display("FAIL spur_clear got %b want 0", bus.resp_err); else n_pass++;
    next_cycle();
    reset_n = 1'b1;
    bus.m0_req = 1'b1; bus.s_gnt = 1'b1;
    @(negedge clk);
    n_total++; if (bus.m0_gnt !== 1'b1) $display("FAIL spur_cnt0a got %b want 1", bus.m0_gnt); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.m0_gnt !== 1'b1) $display("FAIL spur_cnt0b got %b want 1", bus.m0_gnt); else n_pass++;
    next_cycle();
    idle_inputs();
  endtask

  // Entered with two transactions outstanding from test_spurious; reset drops them.
  task automatic test_reset_midflight();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.resp_err !== 1'b0 || bus.s_req !== 1'b0) $display("FAIL mid_after got err=%b req=%b want 0/0", bus.resp_err, bus.s_req); else n_pass++;
    next_cycle();
    bus.s_rvalid = 1'b1; bus.s_rdata = 32'h44;
    @(negedge clk);
    n_total++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) $display("FAIL mid_late_rv got %b%b want 00", bus.m0_rvalid, bus.m1_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_total++; if (bus.resp_err !== 1'b1) $display("FAIL mid_err got %b want 1", bus.resp_err); else n_pass++;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_fifo_full();
    test_mux();
    test_contention();
    test_interleave();
    test_spurious();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
